// File: rtl/instr_fetch_r32i.sv
// Fetch stage for the R32I core: owns the PC, issues one instruction-memory request at a time,
// holds the returned word for decode/execute and redirects on that path's branch controls.
module instr_fetch_r32i #(
    parameter int               dataW    = 32,
    parameter logic [dataW-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    output logic             IMemReq,
    output logic [dataW-1:0] IMemAddr,
    input  logic [dataW-1:0] IMemRdata,
    input  logic             IMemValid,
    output logic [dataW-1:0] rawIns,
    output logic [dataW-1:0] ProgAddr,
    output logic [dataW-1:0] LinkAddr,
    output logic             InsValid,
    input  logic             InsAccept,
    input  logic             TestBranch,
    input  logic             BranchCond,
    input  logic             AlwaysBranch,
    input  logic             AbsoluteBranch,
    input  logic [dataW-1:0] BranchAddr,
    input  logic [dataW-1:0] BranchOffset,
    output logic             MisalignFault
);

    localparam logic [dataW-1:0] WORD_STEP = 32'd4;
    localparam logic [dataW-1:0] LSB_CLEAR = ~32'd1;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t           state_r, state_s;
    logic [dataW-1:0] pc_r, pc_s;
    logic             req_r, req_s;
    logic [dataW-1:0] addr_r, addr_s;
    logic [dataW-1:0] ins_r, ins_s;
    logic [dataW-1:0] prog_r, prog_s;
    logic [dataW-1:0] link_r, link_s;
    logic             valid_r, valid_s;
    logic             fault_r, fault_s;
    logic             taken_s;
    logic             misalign_s;
    logic [dataW-1:0] target_s;
    logic [dataW-1:0] redirect_s;

    // Branch resolution for the held instruction; only consumed in HOLD with InsAccept.
    always_comb begin
        taken_s = AlwaysBranch | (TestBranch & BranchCond);
        if (AbsoluteBranch) begin
            target_s = BranchAddr & LSB_CLEAR;
        end else begin
            target_s = prog_r + BranchOffset;
        end
        misalign_s = taken_s && (target_s[1:0] != 2'b00);
        if (taken_s) begin
            redirect_s = target_s;
        end else begin
            redirect_s = prog_r + WORD_STEP;
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_FETCH;
            pc_r    <= RESET_PC;
            req_r   <= 1'b0;
            addr_r  <= 32'h0000_0000;
            ins_r   <= 32'h0000_0000;
            prog_r  <= 32'h0000_0000;
            link_r  <= 32'h0000_0004;
            valid_r <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            req_r   <= req_s;
            addr_r  <= addr_s;
            ins_r   <= ins_s;
            prog_r  <= prog_s;
            link_r  <= link_s;
            valid_r <= valid_s;
            fault_r <= fault_s;
        end
    end

    // Next-state logic; FETCH lingers one cycle after reset so the request is registered.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_FETCH: begin
                if (req_r) state_s = ST_WAIT;
                else       state_s = ST_FETCH;
            end
            ST_WAIT: begin
                if (IMemValid) state_s = ST_HOLD;
                else           state_s = ST_WAIT;
            end
            ST_HOLD: begin
                if (!InsAccept)     state_s = ST_HOLD;
                else if (misalign_s) state_s = ST_FAULT;
                else                 state_s = ST_FETCH;
            end
            ST_FAULT: state_s = ST_FAULT;
            default:  state_s = ST_FETCH;
        endcase
    end

    // Next values of the registered outputs and PC.
    always_comb begin
        pc_s    = pc_r;
        req_s   = 1'b0;
        addr_s  = addr_r;
        ins_s   = ins_r;
        prog_s  = prog_r;
        link_s  = link_r;
        valid_s = valid_r;
        fault_s = fault_r;
        case (state_r)
            ST_FETCH: begin
                if (!req_r) begin
                    req_s  = 1'b1;
                    addr_s = pc_r;
                end else begin
                    req_s  = 1'b0;
                end
            end
            ST_WAIT: begin
                if (IMemValid) begin
                    ins_s   = IMemRdata;
                    prog_s  = pc_r;
                    link_s  = pc_r + WORD_STEP;
                    valid_s = 1'b1;
                end else begin
                    valid_s = 1'b0;
                end
            end
            ST_HOLD: begin
                if (InsAccept) begin
                    valid_s = 1'b0;
                    if (misalign_s) begin
                        fault_s = 1'b1;
                    end else begin
                        pc_s   = redirect_s;
                        req_s  = 1'b1;
                        addr_s = redirect_s;
                    end
                end else begin
                    valid_s = 1'b1;
                end
            end
            ST_FAULT: begin
                valid_s = 1'b0;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    assign IMemReq       = req_r;
    assign IMemAddr      = addr_r;
    assign rawIns        = ins_r;
    assign ProgAddr      = prog_r;
    assign LinkAddr      = link_r;
    assign InsValid      = valid_r;
    assign MisalignFault = fault_r;

endmodule
